wb_mem_slave_ctrl: RTL and testbench

Wishbone B4 classic-cycle slave controller sitting directly upstream of the single-port `memory` block. It accepts 32-bit Wishbone reads and writes, validates them, and converts each accepted cycle into the memory's native `adr`/`wen`/bidirectional `data` port. It then returns `ack` or `err` to the master. It owns tri-state arbitration of the shared memory data bus.

---
 rtl/wb_mem_slave_ctrl_pkg.sv | 15 +
 rtl/wb_mem_slave_ctrl.sv | 103 ++++++++++
 tb/tb_wb_mem_slave_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_mem_slave_ctrl_pkg.sv
// Shared types and constants for the Wishbone classic-cycle memory slave controller.
package wb_mem_pkg;

   localparam int         WB_DW       = 32;
   localparam int         WB_AW       = 32;
   localparam logic [3:0] WB_SEL_FULL = 4'hF;

   typedef enum logic [2:0] {IDLE, WRITE, READ, ACK, ERR} wb_state_t;

   // Word index of a byte address; the low two bits only select a byte lane.
   function automatic logic [WB_AW-3:0] word_idx(input logic [WB_AW-1:0] byte_adr);
      return byte_adr[WB_AW-1:2];
   endfunction

endpackage

// File: rtl/wb_mem_slave_ctrl.sv
// Wishbone B4 classic slave that validates 32-bit transfers and turns them into
// single-port memory accesses, owning the tri-state memory data bus.
module wb_mem_slave_ctrl
   import wb_mem_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int RD_LAT = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             wb_cyc_i,
   input  logic             wb_stb_i,
   input  logic             wb_we_i,
   input  logic [WB_AW-1:0] wb_adr_i,
   input  logic [WB_DW-1:0] wb_dat_i,
   input  logic [3:0]       wb_sel_i,
   output logic [WB_DW-1:0] wb_dat_o,
   output logic             wb_ack_o,
   output logic             wb_err_o,
   output logic [WB_AW-1:0] mem_adr,
   output logic             mem_wen,
   inout  wire logic [WB_DW-1:0] mem_data
);

   localparam logic [WB_AW-3:0] DEPTH_W  = (WB_AW-2)'(DEPTH);
   localparam logic [1:0]       CNT_INIT = 2'(RD_LAT-1);

   wb_state_t          state_q, state_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [WB_AW-3:0]   adr_q, adr_d;
   logic [WB_DW-1:0]   wdat_q, wdat_d;
   logic [WB_DW-1:0]   rdat_q, rdat_d;
   logic               req;
   logic               illegal;

   assign req     = wb_cyc_i & wb_stb_i;
   assign illegal = (wb_adr_i[1:0] != 2'b00) || (wb_sel_i != WB_SEL_FULL)
                    || (word_idx(wb_adr_i) >= DEPTH_W);

   always_comb begin
      // NOTE: every *_d gets its hold value first so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (illegal) begin
                  state_d = ERR;
               end else begin
                  adr_d   = word_idx(wb_adr_i);
                  cnt_d   = CNT_INIT;
                  state_d = wb_we_i ? WRITE : READ;
                  if (wb_we_i) wdat_d = wb_dat_i;
               end
            end
         end
         // A write always lands in memory; dropping cyc only suppresses the ack.
         WRITE: state_d = wb_cyc_i ? ACK : IDLE;
         READ: begin
            if (!wb_cyc_i) begin
               state_d = IDLE;
            end else if (cnt_q == 2'd0) begin
               rdat_d  = mem_data;
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ACK:     state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         adr_q   <= '0;
         wdat_q  <= '0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
      end
   end

   assign wb_ack_o = (state_q == ACK);
   assign wb_err_o = (state_q == ERR);
   assign wb_dat_o = rdat_q;
   assign mem_adr  = {2'b00, adr_q};
   assign mem_wen  = (state_q == WRITE);
   // The driver follows mem_wen directly, so release coincides with mem_wen falling.
   assign mem_data = mem_wen ? wdat_q : {WB_DW{1'bz}};

endmodule

// File: tb/tb_wb_mem_slave_ctrl.sv
// Self-checking bench: two controllers (RD_LAT 1 and 3), each with a behavioural
// memory, checked against a word-array reference of Wishbone transfer rules.
module tb_wb_mem_slave_ctrl;
   import wb_mem_pkg::*;

   localparam int DEPTH = 256;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   int          act;
   logic        cyc_drv, stb_drv, we_drv;
   logic [31:0] adr_drv, dat_drv;
   logic [3:0]  sel_drv;
   logic        cyc1, cyc3;
   assign cyc1 = cyc_drv && (act == 0);
   assign cyc3 = cyc_drv && (act == 1);

   logic [31:0] dat_o1, dat_o3, madr1, madr3;
   logic        ack1, ack3, err1, err3, wen1, wen3;
   wire  [31:0] mdata1, mdata3;

   wb_mem_slave_ctrl #(.DEPTH(DEPTH), .RD_LAT(1)) u_dut1 (
      .clock(clock), .reset_n(reset_n),
      .wb_cyc_i(cyc1), .wb_stb_i(stb_drv), .wb_we_i(we_drv),
      .wb_adr_i(adr_drv), .wb_dat_i(dat_drv), .wb_sel_i(sel_drv),
      .wb_dat_o(dat_o1), .wb_ack_o(ack1), .wb_err_o(err1),
      .mem_adr(madr1), .mem_wen(wen1), .mem_data(mdata1)
   );

   wb_mem_slave_ctrl #(.DEPTH(DEPTH), .RD_LAT(3)) u_dut3 (
      .clock(clock), .reset_n(reset_n),
      .wb_cyc_i(cyc3), .wb_stb_i(stb_drv), .wb_we_i(we_drv),
      .wb_adr_i(adr_drv), .wb_dat_i(dat_drv), .wb_sel_i(sel_drv),
      .wb_dat_o(dat_o3), .wb_ack_o(ack3), .wb_err_o(err3),
      .mem_adr(madr3), .mem_wen(wen3), .mem_data(mdata3)
   );

   // Behavioural memories: latency 1 is combinational, latency 3 adds two flop stages.
   logic [31:0] mem1 [DEPTH];
   logic [31:0] mem3 [DEPTH];
   logic [31:0] pipe3 [2];
   bit          mem_loaded = 1'b0;

   function automatic logic [31:0] pat(input int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   always @(posedge clock) begin
      if (!mem_loaded) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem1[i] <= pat(i);
            mem3[i] <= pat(i);
         end
         mem_loaded <= 1'b1;
      end else begin
         if (wen1) mem1[madr1[7:0]] <= mdata1;
         if (wen3) mem3[madr3[7:0]] <= mdata3;
      end
      pipe3[0] <= mem3[madr3[7:0]];
      pipe3[1] <= pipe3[0];
   end

   assign mdata1 = wen1 ? 32'bz : mem1[madr1[7:0]];
   assign mdata3 = wen3 ? 32'bz : pipe3[1];

   logic [31:0] dat_m, madr_m, mdata_m;
   logic        ack_m, err_m, wen_m;
   always_comb begin
      dat_m = dat_o1; madr_m = madr1; mdata_m = mdata1;
      ack_m = ack1;   err_m = err1;   wen_m = wen1;
      if (act == 1) begin
         dat_m = dat_o3; madr_m = madr3; mdata_m = mdata3;
         ack_m = ack3;   err_m = err3;   wen_m = wen3;
      end
   end

   // Reference model: expected memory contents and last completed read per instance.
   logic [31:0] ref_mem [2][DEPTH];
   logic [31:0] last_rd [2];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int mem_diffs(input int inst);
      int n = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (inst == 0 && mem1[i] !== ref_mem[0][i]) n++;
         if (inst == 1 && mem3[i] !== ref_mem[1][i]) n++;
      end
      return n;
   endfunction

   // One classic cycle observed over a fixed 12-cycle window after the sampling edge.
   task automatic xfer(input int inst, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int drop_at,
                       output int ack_cyc, output int ack_n, output int err_cyc, output int err_n,
                       output int wen_n, output logic [31:0] wen_adr, output logic [31:0] wen_dat,
                       output logic [31:0] rdata, output logic both);
      ack_cyc = 0; ack_n = 0; err_cyc = 0; err_n = 0; wen_n = 0;
      wen_adr = '0; wen_dat = '0; rdata = '0; both = 1'b0;
      act = inst; we_drv = w; adr_drv = a; dat_drv = d; sel_drv = s;
      cyc_drv = 1'b1; stb_drv = 1'b1;
      @(posedge clock);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clock);
         if (ack_m && err_m) both = 1'b1;
         if (wen_m) begin
            wen_n++;
            wen_adr = madr_m;
            wen_dat = mdata_m;
         end
         if (ack_m) begin
            ack_n++;
            if (ack_cyc == 0) begin
               ack_cyc = c;
               rdata   = dat_m;
            end
         end
         if (err_m) begin
            err_n++;
            if (err_cyc == 0) err_cyc = c;
         end
         if (ack_m || err_m || c == drop_at) begin
            cyc_drv = 1'b0;
            stb_drv = 1'b0;
         end
      end
   endtask

   task automatic run(input int inst, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int drop_at, input string tag);
      int lat, word, exp_ack, exp_err, exp_wen;
      int ack_cyc, ack_n, err_cyc, err_n, wen_n;
      logic [31:0] wen_adr, wen_dat, rdata;
      logic both, ok;
      lat  = (inst == 0) ? 1 : 3;
      ok   = (a[1:0] == 2'b00) && (s == WB_SEL_FULL) && ((a >> 2) < 32'(DEPTH));
      word = int'(a[9:2]);
      exp_ack = 0; exp_err = 0; exp_wen = 0;
      if (!ok) begin
         exp_err = 1;
      end else if (w) begin
         exp_wen = 1;
         if (drop_at != 1) exp_ack = 2;
      end else if (drop_at == 0 || drop_at > lat) begin
         exp_ack = 1 + lat;
      end
      xfer(inst, w, a, d, s, drop_at, ack_cyc, ack_n, err_cyc, err_n, wen_n,
           wen_adr, wen_dat, rdata, both);
      if (ok && w) ref_mem[inst][word] = d;
      if (ok && !w && exp_ack != 0) begin
         check({tag, "_rdata"}, rdata, ref_mem[inst][word]);
         last_rd[inst] = ref_mem[inst][word];
      end
      check({tag, "_ack_cycle"}, 32'(ack_cyc), 32'(exp_ack));
      check({tag, "_ack_count"}, 32'(ack_n), (exp_ack != 0) ? 32'd1 : 32'd0);
      check({tag, "_err_cycle"}, 32'(err_cyc), exp_err ? 32'd1 : 32'd0);
      check({tag, "_err_count"}, 32'(err_n), 32'(exp_err));
      check({tag, "_wen_cycles"}, 32'(wen_n), 32'(exp_wen));
      if (exp_wen != 0) begin
         check({tag, "_wen_adr"}, wen_adr, a >> 2);
         check({tag, "_wen_data"}, wen_dat, d);
      end
      check({tag, "_ack_err_excl"}, {31'b0, both}, 32'd0);
      check({tag, "_dat_o_hold"}, dat_m, last_rd[inst]);
      check({tag, "_mem_contents"}, 32'(mem_diffs(inst)), 32'd0);
   endtask

   int          kind;
   logic [31:0] ra;
   logic [3:0]  rs;
   int          quiet_acks;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[0][i] = pat(i);
         ref_mem[1][i] = pat(i);
      end
      last_rd[0] = '0; last_rd[1] = '0;
      act = 0; cyc_drv = 0; stb_drv = 0; we_drv = 0;
      adr_drv = '0; dat_drv = '0; sel_drv = '0;
      reset_n = 1'b0;
      #1;
      check("rst_dat_o1", dat_o1, 32'd0);
      check("rst_ack1", {31'b0, ack1}, 32'd0);
      check("rst_err1", {31'b0, err1}, 32'd0);
      check("rst_wen1", {31'b0, wen1}, 32'd0);
      check("rst_madr1", madr1, 32'd0);
      check("rst_dat_o3", dat_o3, 32'd0);
      check("rst_ack3", {31'b0, ack3}, 32'd0);
      check("rst_err3", {31'b0, err3}, 32'd0);
      check("rst_wen3", {31'b0, wen3}, 32'd0);
      check("rst_madr3", madr3, 32'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      run(0, 1'b1, 32'h28, 32'hDEADBEEF, 4'hF, 0, "wr_w10");
      run(0, 1'b1, 32'h2C, 32'hFEEDBEEF, 4'hF, 0, "wr_w11");
      run(0, 1'b1, 32'h30, 32'hFADEBEED, 4'hF, 0, "wr_w12");
      run(0, 1'b1, 32'h34, 32'hBEEFFADE, 4'hF, 0, "wr_w13");
      run(0, 1'b0, 32'h30, 32'h0, 4'hF, 0, "rd_w12");
      check("rd_w12_value", dat_o1, 32'hFADEBEED);
      check("rd_w12_bus_known", {31'b0, $isunknown(mdata1)}, 32'd0);

      run(0, 1'b1, 32'h29, 32'h11111111, 4'hF, 0, "misaligned");
      run(0, 1'b1, 32'h2C, 32'h22222222, 4'h3, 0, "partial_sel");
      run(0, 1'b0, 32'h400, 32'h0, 4'hF, 0, "out_of_range");

      run(1, 1'b1, 32'h40, 32'h5A5A1234, 4'hF, 0, "lat3_wr");
      run(1, 1'b0, 32'h40, 32'h0, 4'hF, 2, "lat3_abort");
      run(1, 1'b0, 32'h40, 32'h0, 4'hF, 0, "lat3_rd");
      run(1, 1'b0, 32'h44, 32'h0, 4'hF, 0, "lat3_rd_init");
      run(0, 1'b1, 32'h80, 32'h0BADF00D, 4'hF, 1, "wr_cyc_drop");

      // Reset asserted in the middle of a WRITE cycle.
      act = 0; we_drv = 1'b1; adr_drv = 32'h28; dat_drv = 32'h12345678; sel_drv = 4'hF;
      cyc_drv = 1'b1; stb_drv = 1'b1;
      @(posedge clock);
      #2;
      check("rst_mid_wen_before", {31'b0, wen1}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_wen", {31'b0, wen1}, 32'd0);
      check("rst_mid_madr", madr1, 32'd0);
      check("rst_mid_bus_released", mdata1, ref_mem[0][0]);
      cyc_drv = 1'b0; stb_drv = 1'b0;
      quiet_acks = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         if (ack1 || err1) quiet_acks++;
      end
      check("rst_mid_no_ack", 32'(quiet_acks), 32'd0);
      reset_n = 1'b1;
      last_rd[0] = '0; last_rd[1] = '0;
      @(negedge clock);
      run(0, 1'b0, 32'h28, 32'h0, 4'hF, 0, "rd_after_rst");
      check("rd_after_rst_value", dat_o1, 32'hDEADBEEF);

      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 9));
         ra   = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
         rs   = 4'hF;
         if (kind == 0) ra[1:0] = 2'($urandom_range(1, 3));
         else if (kind == 1) rs = 4'($urandom_range(0, 14));
         else if (kind == 2) ra = ra + 32'h400 * $urandom_range(1, 8);
         run(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom, rs, 0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
